// File: rtl/warp_dispatcher.sv
`default_nettype none
// =============================================================================
// warp_dispatcher - binds kernel descriptors to free SIMD cores, serialises completions
// Revision: 1.0
// =============================================================================
module warp_dispatcher #(
  parameter int NUM_SIMD_CORES    = 4,
  parameter int LOG2_THREAD_COUNT = 3,
  parameter int THREAD_COUNT      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_kernel,
  input  logic [LOG2_THREAD_COUNT-1:0] kernel_thread_count,
  input  logic [31:0]                  kernel_start_pc,
  input  logic [3:0]                   kernel_warp_id,
  output logic                         kernel_ready,
  output logic                         overflow,
  output logic [NUM_SIMD_CORES-1:0]    core_launch,
  output logic [31:0]                  core_start_pc,
  output logic [THREAD_COUNT-1:0]      core_thread_mask,
  output logic [3:0]                   core_warp_id,
  input  logic [NUM_SIMD_CORES-1:0]    core_done,
  output logic [3:0]                   finished_warp_id,
  output logic                         all_idle
);

  localparam int         CIW     = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;
  localparam int         CNTW    = $clog2(NUM_SIMD_CORES + 1);
  localparam logic [3:0] NO_WARP = 4'hF;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LAUNCH  = 2'd1,
    RUNNING = 2'd2,
    DRAIN   = 2'd3
  } core_state_e;

  core_state_e                  state_q     [NUM_SIMD_CORES];
  core_state_e                  state_d     [NUM_SIMD_CORES];
  logic [3:0]                   core_wid_q  [NUM_SIMD_CORES];
  logic [3:0]                   core_wid_d  [NUM_SIMD_CORES];
  logic [3:0]                   fifo_wid_q  [NUM_SIMD_CORES];
  logic [3:0]                   fifo_wid_d  [NUM_SIMD_CORES];
  logic [CIW-1:0]               fifo_core_q [NUM_SIMD_CORES];
  logic [CIW-1:0]               fifo_core_d [NUM_SIMD_CORES];
  logic [CNTW-1:0]              fifo_cnt_q, fifo_cnt_d, wr_ptr;

  logic                         pend_valid_q, pend_valid_d;
  logic [LOG2_THREAD_COUNT-1:0] pend_count_q, pend_count_d;
  logic [31:0]                  pend_pc_q, pend_pc_d;
  logic [3:0]                   pend_wid_q, pend_wid_d;

  logic [NUM_SIMD_CORES-1:0]    core_launch_q, core_launch_d;
  logic [31:0]                  core_start_pc_q, core_start_pc_d;
  logic [THREAD_COUNT-1:0]      core_thread_mask_q, core_thread_mask_d;
  logic [3:0]                   core_warp_id_q, core_warp_id_d;
  logic [3:0]                   finished_warp_id_q, finished_warp_id_d;
  logic                         overflow_q, overflow_d;

  logic                         accept, any_free, dispatch, all_free;
  logic [CIW-1:0]               sel;

  always_comb begin
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      state_d[i]     = state_q[i];
      core_wid_d[i]  = core_wid_q[i];
      fifo_wid_d[i]  = fifo_wid_q[i];
      fifo_core_d[i] = fifo_core_q[i];
    end
    pend_valid_d       = pend_valid_q;
    pend_count_d       = pend_count_q;
    pend_pc_d          = pend_pc_q;
    pend_wid_d         = pend_wid_q;
    core_launch_d      = '0;
    core_start_pc_d    = core_start_pc_q;
    core_thread_mask_d = core_thread_mask_q;
    core_warp_id_d     = core_warp_id_q;
    finished_warp_id_d = NO_WARP;
    overflow_d         = overflow_q;
    wr_ptr             = fifo_cnt_q;

    accept = valid_kernel && (kernel_thread_count != '0) && (kernel_warp_id != NO_WARP);

    // Scan downward so the last hit is the lowest-indexed free core.
    any_free = 1'b0;
    sel      = '0;
    for (int i = NUM_SIMD_CORES - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        any_free = 1'b1;
        sel      = CIW'(i);
      end
    end
    dispatch = pend_valid_q && any_free;

    if (dispatch) begin
      state_d[sel]       = LAUNCH;
      core_wid_d[sel]    = pend_wid_q;
      core_launch_d[sel] = 1'b1;
      core_start_pc_d    = pend_pc_q;
      core_warp_id_d     = pend_wid_q;
      for (int i = 0; i < THREAD_COUNT; i++) begin
        core_thread_mask_d[i] = (i < int'(pend_count_q));
      end
      pend_valid_d = 1'b0;
    end

    if (accept) begin
      if (!pend_valid_q || dispatch) begin
        pend_valid_d = 1'b1;
        pend_count_d = kernel_thread_count;
        pend_pc_d    = kernel_start_pc;
        pend_wid_d   = kernel_warp_id;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Pop before push so a head entry and new completions share one edge.
    if (fifo_cnt_q != '0) begin
      finished_warp_id_d      = fifo_wid_q[0];
      state_d[fifo_core_q[0]] = FREE;
      for (int i = 0; i < NUM_SIMD_CORES - 1; i++) begin
        fifo_wid_d[i]  = fifo_wid_q[i+1];
        fifo_core_d[i] = fifo_core_q[i+1];
      end
      wr_ptr = fifo_cnt_q - 1'b1;
    end

    for (int k = 0; k < NUM_SIMD_CORES; k++) begin
      if (state_q[k] == LAUNCH) begin
        state_d[k] = RUNNING;
      end
      if ((state_q[k] == LAUNCH || state_q[k] == RUNNING) && core_done[k]) begin
        state_d[k]                     = DRAIN;
        fifo_wid_d[wr_ptr[CIW-1:0]]    = core_wid_q[k];
        fifo_core_d[wr_ptr[CIW-1:0]]   = CIW'(k);
        wr_ptr                         = wr_ptr + 1'b1;
      end
    end
    fifo_cnt_d = wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        state_q[i]     <= FREE;
        core_wid_q[i]  <= '0;
        fifo_wid_q[i]  <= '0;
        fifo_core_q[i] <= '0;
      end
      fifo_cnt_q         <= '0;
      pend_valid_q       <= 1'b0;
      pend_count_q       <= '0;
      pend_pc_q          <= '0;
      pend_wid_q         <= '0;
      core_launch_q      <= '0;
      core_start_pc_q    <= '0;
      core_thread_mask_q <= '0;
      core_warp_id_q     <= '0;
      finished_warp_id_q <= NO_WARP;
      overflow_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        state_q[i]     <= state_d[i];
        core_wid_q[i]  <= core_wid_d[i];
        fifo_wid_q[i]  <= fifo_wid_d[i];
        fifo_core_q[i] <= fifo_core_d[i];
      end
      fifo_cnt_q         <= fifo_cnt_d;
      pend_valid_q       <= pend_valid_d;
      pend_count_q       <= pend_count_d;
      pend_pc_q          <= pend_pc_d;
      pend_wid_q         <= pend_wid_d;
      core_launch_q      <= core_launch_d;
      core_start_pc_q    <= core_start_pc_d;
      core_thread_mask_q <= core_thread_mask_d;
      core_warp_id_q     <= core_warp_id_d;
      finished_warp_id_q <= finished_warp_id_d;
      overflow_q         <= overflow_d;
    end
  end

  always_comb begin
    all_free = 1'b1;
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      if (state_q[i] != FREE) all_free = 1'b0;
    end
  end

  assign kernel_ready     = !pend_valid_q;
  assign all_idle         = all_free && !pend_valid_q && (fifo_cnt_q == '0);
  assign overflow         = overflow_q;
  assign core_launch      = core_launch_q;
  assign core_start_pc    = core_start_pc_q;
  assign core_thread_mask = core_thread_mask_q;
  assign core_warp_id     = core_warp_id_q;
  assign finished_warp_id = finished_warp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_warp_dispatcher.sv
`default_nettype none
// =============================================================================
// tb_warp_dispatcher - scoreboard bench for warp_dispatcher
// Revision: 1.0
// =============================================================================
module tb_warp_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_kernel = 1'b0;
  logic [2:0]  kernel_thread_count = '0;
  logic [31:0] kernel_start_pc = '0;
  logic [3:0]  kernel_warp_id = '0;
  logic        kernel_ready;
  logic        overflow;
  logic [3:0]  core_launch;
  logic [31:0] core_start_pc;
  logic [7:0]  core_thread_mask;
  logic [3:0]  core_warp_id;
  logic [3:0]  core_done = '0;
  logic [3:0]  finished_warp_id;
  logic        all_idle;

  warp_dispatcher #(
    .NUM_SIMD_CORES(4),
    .LOG2_THREAD_COUNT(3),
    .THREAD_COUNT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_kernel(valid_kernel),
    .kernel_thread_count(kernel_thread_count),
    .kernel_start_pc(kernel_start_pc),
    .kernel_warp_id(kernel_warp_id),
    .kernel_ready(kernel_ready),
    .overflow(overflow),
    .core_launch(core_launch),
    .core_start_pc(core_start_pc),
    .core_thread_mask(core_thread_mask),
    .core_warp_id(core_warp_id),
    .core_done(core_done),
    .finished_warp_id(finished_warp_id),
    .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  launch;
    logic [31:0] pc;
    logic [7:0]  mask;
    logic [3:0]  wid;
  } launch_t;

  launch_t    exp_launch[$];
  logic [3:0] exp_fin[$];
  launch_t    mon_e;
  logic [3:0] mon_w;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [2:0] cnt, input logic [31:0] pc, input logic [3:0] wid);
    valid_kernel        = 1'b1;
    kernel_thread_count = cnt;
    kernel_start_pc     = pc;
    kernel_warp_id      = wid;
    tick();
    valid_kernel        = 1'b0;
  endtask

  task automatic done(input logic [3:0] m);
    core_done = m;
    tick();
    core_done = '0;
  endtask

  task automatic exp_l(input logic [3:0] l, input logic [31:0] pc, input logic [7:0] mask,
                       input logic [3:0] wid);
    launch_t e;
    e.launch = l; e.pc = pc; e.mask = mask; e.wid = wid;
    exp_launch.push_back(e);
  endtask

  // Monitor: every launch pulse and every reported ID must match the scoreboard head.
  always @(negedge clk) begin
    if (core_launch !== 4'b0000) begin
      if (exp_launch.size() == 0) begin
        chk("unexpected_launch", {28'h0, core_launch}, 32'h0);
      end else begin
        mon_e = exp_launch.pop_front();
        chk("launch_vec", {28'h0, core_launch}, {28'h0, mon_e.launch});
        chk("launch_pc", core_start_pc, mon_e.pc);
        chk("launch_mask", {24'h0, core_thread_mask}, {24'h0, mon_e.mask});
        chk("launch_wid", {28'h0, core_warp_id}, {28'h0, mon_e.wid});
      end
    end
    if (finished_warp_id !== 4'hF) begin
      if (exp_fin.size() == 0) begin
        chk("unexpected_finish", {28'h0, finished_warp_id}, 32'hF);
      end else begin
        mon_w = exp_fin.pop_front();
        chk("finished_wid", {28'h0, finished_warp_id}, {28'h0, mon_w});
      end
    end
  end

  initial begin
    // Reset
    ticks(2);
    chk("rst_finished", {28'h0, finished_warp_id}, 32'hF);
    chk("rst_launch", {28'h0, core_launch}, 32'h0);
    chk("rst_pc", core_start_pc, 32'h0);
    chk("rst_ready", {31'h0, kernel_ready}, 32'h1);
    chk("rst_idle", {31'h0, all_idle}, 32'h1);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b1;
    tick();

    // Single warp
    exp_l(4'b0001, 32'h100, 8'h07, 4'd2);
    send(3'd3, 32'h100, 4'd2);
    chk("single_pending_ready", {31'h0, kernel_ready}, 32'h0);
    chk("single_not_idle", {31'h0, all_idle}, 32'h0);
    ticks(3);
    exp_fin.push_back(4'd2);
    done(4'b0001);
    ticks(3);
    chk("single_idle_after", {31'h0, all_idle}, 32'h1);

    // Fill all cores, 5th waits, 6th overflows
    exp_l(4'b0001, 32'h200, 8'h7F, 4'd0);
    exp_l(4'b0010, 32'h204, 8'h01, 4'd1);
    exp_l(4'b0100, 32'h208, 8'h0F, 4'd2);
    exp_l(4'b1000, 32'h20C, 8'h03, 4'd3);
    send(3'd7, 32'h200, 4'd0);
    send(3'd1, 32'h204, 4'd1);
    send(3'd4, 32'h208, 4'd2);
    send(3'd2, 32'h20C, 4'd3);
    exp_l(4'b0100, 32'h210, 8'h1F, 4'd4);
    send(3'd5, 32'h210, 4'd4);
    chk("fill_ready_low", {31'h0, kernel_ready}, 32'h0);
    chk("fill_no_overflow_yet", {31'h0, overflow}, 32'h0);
    send(3'd6, 32'h214, 4'd5);
    chk("fill_overflow", {31'h0, overflow}, 32'h1);
    chk("fill_ready_still_low", {31'h0, kernel_ready}, 32'h0);
    ticks(3);
    chk("fill_waiting", {31'h0, kernel_ready}, 32'h0);
    exp_fin.push_back(4'd2);
    done(4'b0100);
    ticks(4);
    chk("fill_ready_after_free", {31'h0, kernel_ready}, 32'h1);
    exp_fin.push_back(4'd0);
    exp_fin.push_back(4'd1);
    exp_fin.push_back(4'd3);
    exp_fin.push_back(4'd4);
    done(4'b1011);
    done(4'b0100);
    ticks(6);
    chk("fill_overflow_sticky", {31'h0, overflow}, 32'h1);
    chk("fill_idle_after", {31'h0, all_idle}, 32'h1);

    // Simultaneous completion and relaunch order
    exp_l(4'b0001, 32'h300, 8'h01, 4'd6);
    exp_l(4'b0010, 32'h304, 8'h03, 4'd7);
    exp_l(4'b0100, 32'h308, 8'h07, 4'd8);
    exp_l(4'b1000, 32'h30C, 8'h0F, 4'd9);
    send(3'd1, 32'h300, 4'd6);
    send(3'd2, 32'h304, 4'd7);
    send(3'd3, 32'h308, 4'd8);
    send(3'd4, 32'h30C, 4'd9);
    ticks(3);
    exp_fin.push_back(4'd7);
    exp_fin.push_back(4'd9);
    exp_l(4'b0010, 32'h400, 8'h07, 4'd10);
    exp_l(4'b1000, 32'h404, 8'h7F, 4'd11);
    done(4'b1010);
    send(3'd3, 32'h400, 4'd10);
    send(3'd7, 32'h404, 4'd11);
    ticks(3);
    exp_fin.push_back(4'd6);
    exp_fin.push_back(4'd10);
    exp_fin.push_back(4'd8);
    exp_fin.push_back(4'd11);
    done(4'b1111);
    ticks(6);
    chk("simul_idle_after", {31'h0, all_idle}, 32'h1);

    // Invalid descriptors and stray completion
    send(3'd0, 32'h600, 4'd3);
    chk("inv_count0_ready", {31'h0, kernel_ready}, 32'h1);
    send(3'd5, 32'h604, 4'hF);
    chk("inv_widF_ready", {31'h0, kernel_ready}, 32'h1);
    done(4'b0100);
    ticks(4);
    chk("inv_idle", {31'h0, all_idle}, 32'h1);

    // Reset mid-flight
    exp_l(4'b0001, 32'h500, 8'h03, 4'd1);
    exp_l(4'b0010, 32'h504, 8'h03, 4'd2);
    send(3'd2, 32'h500, 4'd1);
    send(3'd2, 32'h504, 4'd2);
    send(3'd2, 32'h508, 4'd3);
    chk("mid_pending_full", {31'h0, kernel_ready}, 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", {31'h0, kernel_ready}, 32'h1);
    chk("mid_rst_idle", {31'h0, all_idle}, 32'h1);
    chk("mid_rst_launch", {28'h0, core_launch}, 32'h0);
    chk("mid_rst_finished", {28'h0, finished_warp_id}, 32'hF);
    chk("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b1;
    tick();
    done(4'b0011);
    ticks(5);
    chk("mid_idle_after", {31'h0, all_idle}, 32'h1);

    chk("launch_queue_drained", exp_launch.size(), 32'd0);
    chk("finish_queue_drained", exp_fin.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warp_dispatcher.md
# warp_dispatcher

Downstream stage of the warp scheduler: accepts one kernel descriptor per cycle (thread count, start PC, warp ID), binds it to the lowest-indexed free SIMD core, and emits a one-cycle launch pulse carrying a thread mask. It collects per-core completion pulses, serialises them, and returns each finished warp ID to the scheduler one per cycle on `finished_warp_id`. That port is also how the scheduler frees the warp ID.

## Interface
- NUM_SIMD_CORES, 4, number of SIMD cores served
- LOG2_THREAD_COUNT, 3, width of the thread-count field
- THREAD_COUNT, 8, width of the per-core thread mask
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- valid_kernel  in  1  descriptor valid this cycle
- kernel_thread_count  in  LOG2_THREAD_COUNT  threads in warp
- kernel_start_pc  in  32  warp start PC
- kernel_warp_id  in  4  warp ID; 4'hF = none
- kernel_ready  out  1  pending slot empty
- overflow  out  1  sticky; descriptor dropped
- core_launch  out  NUM_SIMD_CORES  one-hot launch pulse
- core_start_pc  out  32  PC for launched core
- core_thread_mask  out  THREAD_COUNT  active-thread mask
- core_warp_id  out  4  warp ID for launched core
- core_done  in  NUM_SIMD_CORES  per-core one-cycle completion pulse
- finished_warp_id  out  4  completed warp ID; 4'hF when none
- all_idle  out  1  every core FREE, pending empty, completion FIFO empty

## Operation
- **Acceptance**
  - A descriptor is accepted when `valid_kernel=1`, `kernel_thread_count!=0` and `kernel_warp_id!=4'hF`. Any other descriptor is ignored.
  - Accepted descriptors go into a one-entry pending register.
- **Per-core state: FREE -> LAUNCH -> RUNNING -> DRAIN -> FREE.** Each core stores its bound warp ID.
  - FREE -> LAUNCH: the core is selected for dispatch.
  - LAUNCH -> RUNNING: unconditional after one cycle.
  - LAUNCH/RUNNING -> DRAIN: `core_done[k]=1`. The core's warp ID is pushed into the completion FIFO.
  - DRAIN -> FREE: its FIFO entry is popped.
- **Dispatch**
  - When pending is valid and at least one core is FREE, select the lowest-index FREE core.
  - Register outputs: `core_launch[k]=1`, PC, warp ID, and mask = low `kernel_thread_count` bits set. Examples: count 3 -> 8'b0000_0111; count 7 -> 8'b0111_1111.
- **Pending slot**
  - Pending empties on dispatch.
  - A new accepted descriptor may load at the same edge that pending dispatches.
  - If pending is full and not dispatching, an accepted descriptor is dropped and `overflow` sets (cleared only by reset).
- **Completion**
  - `core_done` on a FREE or DRAIN core is ignored.
  - Simultaneous dones are pushed in ascending core-index order.
  - The FIFO depth is NUM_SIMD_CORES. It cannot overflow, because a core is not freed until its entry is popped.
- **Report**
  - Each edge: if the FIFO is non-empty, pop the head into `finished_warp_id`; otherwise drive 4'hF.
  - Each completed warp ID is therefore presented for exactly one cycle.

## Timing
- **Reset** (`rst=0` at an edge): all cores FREE, pending empty, FIFO empty, `core_launch=0`, `core_start_pc=0`, `core_thread_mask=0`, `core_warp_id=0`, `finished_warp_id=4'hF`, `overflow=0`, `kernel_ready=1`, `all_idle=1`.
  - Reset mid-operation discards in-flight warps; no finished IDs are reported for them.
- **Kernel-to-launch latency:** descriptor sampled at edge E -> pending from E -> `core_launch` high for the cycle after edge E+1, if a core is FREE at E+1.
- **Done-to-report latency:** `core_done[k]` sampled at edge D -> pushed at D -> `finished_warp_id` valid for the cycle after D+1, when the FIFO was empty before D.
  - Each further simultaneous completion appears one cycle later.
- **Core reuse:** a core popped at edge P is FREE from P and may be selected at edge P+1 at the earliest.
- **Outputs:** `kernel_ready` and `all_idle` are combinational from registered state. `core_launch` is never high for more than one core or for more than one cycle per dispatch.

## Test plan
- **Reset:** hold `rst=0` 2 cycles -> `finished_warp_id=4'hF`, `core_launch=0`, `kernel_ready=1`, `all_idle=1`.
- **Single warp:** count=3, PC=0x100, ID=2 at edge 1 -> after edge 2, `core_launch=4'b0001`, mask 8'h07, PC 0x100, ID 2. Pulse `core_done[0]` at edge 5 -> `finished_warp_id=2` for exactly one cycle after edge 6, then 4'hF.
- **Fill all cores:** IDs 0,1,2,3 on consecutive cycles -> launches on cores 0,1,2,3 in order. A 5th (ID 4) waits with `kernel_ready=0`. A 6th at the next cycle -> `overflow=1`, ID 5 never launched.
- **Simultaneous completion:** `core_done=4'b1010` while cores 1 and 3 run IDs 7 and 9 -> `finished_warp_id` shows 7 then 9 on consecutive cycles. Core 1 is relaunched before core 3.
- **Invalid input:** `valid_kernel=1` with count 0, or with ID 4'hF -> no launch, pending unchanged. A stray `core_done[2]` on a FREE core -> no report.
- **Reset mid-flight:** two cores RUNNING, pending full, `rst=0` one cycle -> all state cleared. Later `core_done` pulses produce no reports.
